// File: rtl/video_frame_sequencer.sv
// Capture-run sequencer: aligns to the first VSYNC rise, counts pixels/lines/frames,
// flags geometry errors and stops at a frame boundary on request or after num_frames.
module video_frame_sequencer #(
  parameter int unsigned H_WIDTH       = 2448,
  parameter int unsigned V_WIDTH       = 2048,
  parameter logic [23:0] ALIGN_TIMEOUT = 24'd16777215
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] num_frames,
  input  logic        VSYNC,
  input  logic        HSYNC,
  output logic        gen_enable,
  output logic        busy,
  output logic        done,
  output logic        frame_start,
  output logic        line_start,
  output logic [15:0] frame_cnt,
  output logic [12:0] line_cnt,
  output logic        err_h,
  output logic        err_v,
  output logic        err_timeout
);

  localparam logic [12:0] H_LEN = 13'(H_WIDTH);
  localparam logic [12:0] V_LEN = 13'(V_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic        stop_lat_r, stop_lat_s;
  logic [15:0] nf_r, nf_s;
  logic [12:0] pix_r, pix_s;
  logic [23:0] tmo_r, tmo_s;
  logic        vs_prev_r, hs_prev_r;
  logic        gen_en_s, busy_s, done_s, fs_s, ls_s;
  logic [15:0] fcnt_s, fnext_s;
  logic [12:0] lcnt_s, lines_s;
  logic        errh_s, errv_s, errt_s, end_s;
  logic        vs_rise_s, vs_fall_s, hs_rise_s, hs_fall_s, tmo_hit_s;

  assign vs_rise_s = VSYNC & ~vs_prev_r;
  assign vs_fall_s = ~VSYNC & vs_prev_r;
  assign hs_rise_s = HSYNC & ~hs_prev_r;
  assign hs_fall_s = ~HSYNC & hs_prev_r;
  assign tmo_hit_s = ({1'b0, tmo_r} + 25'd1) >= {1'b0, ALIGN_TIMEOUT};

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s    = state_r;
    stop_lat_s = stop_lat_r;
    nf_s       = nf_r;
    pix_s      = pix_r;
    tmo_s      = tmo_r;
    done_s     = 1'b0;
    fs_s       = 1'b0;
    ls_s       = 1'b0;
    fcnt_s     = frame_cnt;
    lcnt_s     = line_cnt;
    errh_s     = err_h;
    errv_s     = err_v;
    errt_s     = err_timeout;
    end_s      = 1'b0;
    // A line ending in the same cycle as the frame is counted before the height check.
    lines_s    = line_cnt + {12'd0, hs_fall_s};
    fnext_s    = frame_cnt + 16'd1;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s    = ALIGN;
          nf_s       = num_frames;
          fcnt_s     = 16'd0;
          lcnt_s     = 13'd0;
          errh_s     = 1'b0;
          errv_s     = 1'b0;
          errt_s     = 1'b0;
          stop_lat_s = 1'b0;
          tmo_s      = 24'd0;
          pix_s      = 13'd0;
        end else begin
          state_s = IDLE;
        end
      end
      ALIGN: begin
        if (stop) begin
          state_s = STOP;
          done_s  = 1'b1;
        end else if (vs_rise_s) begin
          state_s = RUN;
          fs_s    = 1'b1;
          pix_s   = 13'd0;
        end else if (tmo_hit_s) begin
          state_s = STOP;
          done_s  = 1'b1;
          errt_s  = 1'b1;
        end else begin
          tmo_s = tmo_r + 24'd1;
        end
      end
      RUN: begin
        stop_lat_s = stop_lat_r | stop;
        ls_s       = hs_rise_s;
        fs_s       = vs_rise_s;
        if (hs_fall_s) begin
          errh_s = err_h | (pix_r != H_LEN);
          pix_s  = 13'd0;
          lcnt_s = line_cnt + 13'd1;
        end else if (HSYNC) begin
          pix_s = pix_r + 13'd1;
        end else begin
          pix_s = pix_r;
        end
        if (vs_fall_s) begin
          errv_s = err_v | (lines_s != V_LEN);
          lcnt_s = 13'd0;
          fcnt_s = fnext_s;
          end_s  = stop_lat_r | stop | ((nf_r != 16'd0) && (fnext_s == nf_r));
          if (end_s) begin
            state_s = STOP;
            done_s  = 1'b1;
          end else begin
            state_s = RUN;
          end
        end else begin
          end_s = 1'b0;
        end
      end
      STOP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    gen_en_s = (state_s == ALIGN) || (state_s == RUN);
    busy_s   = (state_s != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      stop_lat_r  <= 1'b0;
      nf_r        <= 16'd0;
      pix_r       <= 13'd0;
      tmo_r       <= 24'd0;
      vs_prev_r   <= 1'b0;
      hs_prev_r   <= 1'b0;
      gen_enable  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      frame_cnt   <= 16'd0;
      line_cnt    <= 13'd0;
      err_h       <= 1'b0;
      err_v       <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_r     <= state_s;
      stop_lat_r  <= stop_lat_s;
      nf_r        <= nf_s;
      pix_r       <= pix_s;
      tmo_r       <= tmo_s;
      vs_prev_r   <= gen_enable ? VSYNC : 1'b0;
      hs_prev_r   <= gen_enable ? HSYNC : 1'b0;
      gen_enable  <= gen_en_s;
      busy        <= busy_s;
      done        <= done_s;
      frame_start <= fs_s;
      line_start  <= ls_s;
      frame_cnt   <= fcnt_s;
      line_cnt    <= lcnt_s;
      err_h       <= errh_s;
      err_v       <= errv_s;
      err_timeout <= errt_s;
    end
  end

endmodule

// File: tb/tb_video_frame_sequencer.sv
// Bench for video_frame_sequencer: table of runs (hand + randomized) against a frame-level
// reference model, driven by a queue-based timing generator, plus timeout/reset sequences.
module tb_video_frame_sequencer;
  localparam int HW  = 8;
  localparam int VW  = 4;
  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst, start, stop, VSYNC, HSYNC;
  logic [15:0] num_frames;
  logic        gen_enable, busy, done, frame_start, line_start;
  logic [15:0] frame_cnt;
  logic [12:0] line_cnt;
  logic        err_h, err_v, err_timeout;

  video_frame_sequencer #(.H_WIDTH(HW), .V_WIDTH(VW), .ALIGN_TIMEOUT(24'd50)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .num_frames(num_frames),
    .VSYNC(VSYNC), .HSYNC(HSYNC), .gen_enable(gen_enable), .busy(busy), .done(done),
    .frame_start(frame_start), .line_start(line_start), .frame_cnt(frame_cnt),
    .line_cnt(line_cnt), .err_h(err_h), .err_v(err_v), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nf; int smode; int sframe; int bad_h; int bad_v;
    bit coinc; bit ss_idle; bit restart;
    int exp_frames; bit exp_h; bit exp_v;
  } row_t;

  typedef struct { bit v; bit h; int tag; int fr; } gen_t;

  gen_t gq[$];
  row_t rows[16];
  int   n_tests = 0, n_fail = 0;
  int   n_done, n_fs, n_ls;
  int   cfg_smode, cfg_sframe, cfg_bad_h, cfg_bad_v;
  bit   cfg_coinc, gen_off;
  int   g_next, g_tag, g_cur;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame-level model: which frame ends the run, and which errors land inside it.
  function automatic row_t ref_model(input row_t r);
    row_t o;
    int   last;
    o    = r;
    last = (r.nf != 0) ? r.nf - 1 : 1 << 20;
    if (r.smode != 0 && r.sframe < last) last = r.sframe;
    o.exp_frames = last + 1;
    o.exp_h      = (r.bad_h >= 0) && (r.bad_h <= last);
    o.exp_v      = (r.bad_v >= 0) && (r.bad_v <= last);
    return o;
  endfunction

  // tag 1: first pixel of line 2; tag 2: the VSYNC fall cycle of the frame
  function automatic void build_frame(input int f);
    int nl;
    nl = (f == cfg_bad_v) ? VW - 1 : VW;
    gq.push_back('{1'b1, 1'b0, 0, f});
    for (int l = 0; l < nl; l++) begin
      int len;
      len = (f == cfg_bad_h && l == 1) ? HW - 1 : HW;
      for (int p = 0; p < len; p++) gq.push_back('{1'b1, 1'b1, (l == 2 && p == 0) ? 1 : 0, f});
      if (!(l == nl - 1 && cfg_coinc)) begin
        gq.push_back('{1'b1, 1'b0, 0, f});
        if (l != nl - 1) gq.push_back('{1'b1, 1'b0, 0, f});
      end
    end
    gq.push_back('{1'b0, 1'b0, 2, f});
    gq.push_back('{1'b0, 1'b0, 0, f});
  endfunction

  task automatic step(input logic st, input logic sp);
    gen_t e;
    @(negedge clk);
    if (done) n_done++;
    if (frame_start) n_fs++;
    if (line_start) n_ls++;
    start = st;
    if (!gen_enable || gen_off) begin
      VSYNC = 1'b0; HSYNC = 1'b0; gq.delete();
      g_next = 0; g_tag = 0; g_cur = -1;
      stop = sp;
    end else begin
      if (gq.size() == 0) begin
        build_frame(g_next);
        g_next++;
      end
      e = gq.pop_front();
      VSYNC = e.v; HSYNC = e.h; g_tag = e.tag; g_cur = e.fr;
      stop = sp | ((cfg_smode != 0 && e.fr == cfg_sframe && e.tag == cfg_smode) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic run_row(input row_t r, input int idx);
    int  c;
    bit  restarted;
    string s;
    s = $sformatf("row%0d", idx);
    cfg_smode = r.smode; cfg_sframe = r.sframe; cfg_bad_h = r.bad_h;
    cfg_bad_v = r.bad_v; cfg_coinc = r.coinc;
    n_done = 0; n_fs = 0; n_ls = 0; restarted = 1'b0;
    num_frames = 16'(r.nf);
    step(1'b1, r.ss_idle);
    step(1'b0, 1'b0);
    chk({s, "_gen_en_after_start"}, gen_enable, 1);
    c = 0;
    while (n_done == 0 && c < 3000) begin
      if (r.restart && !restarted && g_cur == 0 && g_tag == 1) begin
        num_frames = 16'd5;
        restarted  = 1'b1;
        step(1'b1, 1'b0);
      end else begin
        step(1'b0, 1'b0);
      end
      c++;
    end
    chk({s, "_done_seen"}, n_done, 1);
    chk({s, "_frame_cnt"}, frame_cnt, r.exp_frames);
    chk({s, "_err_h"}, err_h, r.exp_h);
    chk({s, "_err_v"}, err_v, r.exp_v);
    chk({s, "_err_timeout"}, err_timeout, 0);
    chk({s, "_gen_en_at_done"}, gen_enable, 0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    chk({s, "_busy_after"}, busy, 0);
    chk({s, "_done_count"}, n_done, 1);
    chk({s, "_frame_starts"}, n_fs, r.exp_frames);
    chk({s, "_line_starts"}, n_ls, VW * r.exp_frames - (r.exp_v ? 1 : 0));
    chk({s, "_frame_cnt_hold"}, frame_cnt, r.exp_frames);
    chk({s, "_err_h_hold"}, err_h, r.exp_h);
  endtask

  initial begin
    int j;
    bit found;
    rst = 1'b1; start = 1'b0; stop = 1'b0; VSYNC = 1'b0; HSYNC = 1'b0;
    num_frames = 16'd0; gen_off = 1'b0;
    cfg_smode = 0; cfg_sframe = -1; cfg_bad_h = -1; cfg_bad_v = -1; cfg_coinc = 1'b0;
    g_next = 0; g_tag = 0; g_cur = -1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("reset_state", {gen_enable, busy, done, frame_start, line_start, frame_cnt, line_cnt,
                        err_h, err_v, err_timeout}, 0);
    rst = 1'b0;
    step(1'b0, 1'b0);

    // Timeout: generator held silent.
    gen_off = 1'b1; n_done = 0;
    step(1'b1, 1'b0);
    j = 0;
    while (!err_timeout && j < 200) begin
      step(1'b0, 1'b0);
      j++;
    end
    chk("timeout_cycle", j - 1, TMO);
    chk("timeout_done", done, 1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("timeout_busy", busy, 0);
    chk("timeout_done_count", n_done, 1);
    chk("timeout_gen_en", gen_enable, 0);
    chk("timeout_sticky", err_timeout, 1);
    gen_off = 1'b0;

    // Reset in the middle of frame 1, line 2.
    num_frames = 16'd0; n_done = 0; found = 1'b0;
    step(1'b1, 1'b0);
    for (int c = 0; c < 400 && !found; c++) begin
      step(1'b0, 1'b0);
      found = (g_cur == 1 && g_tag == 1);
    end
    chk("rst_mid_reached", found, 1);
    chk("rst_mid_busy_before", busy, 1);
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0);
    chk("rst_mid_outputs", {gen_enable, busy, done, frame_start, line_start, frame_cnt, line_cnt,
                            err_h, err_v, err_timeout}, 0);
    step(1'b0, 1'b0);
    chk("rst_mid_no_done", n_done, 0);

    rows[0] = '{3, 0, -1, -1, -1, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0};
    rows[1] = '{0, 1,  0, -1, -1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    rows[2] = '{2, 0, -1,  0, -1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0};
    rows[3] = '{1, 0, -1, -1, -1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    rows[4] = '{2, 0, -1, -1,  1, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b1};
    rows[5] = '{2, 2,  1, -1, -1, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0};
    rows[6] = '{2, 0, -1, -1, -1, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0};
    rows[7] = '{2, 0, -1, -1, -1, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0};
    rows[8] = '{0, 2,  0, -1, -1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    rows[9] = '{4, 1,  5, -1,  3, 1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b1};
    for (int i = 10; i < 16; i++) begin
      rows[i].nf      = int'($urandom_range(0, 4));
      rows[i].smode   = (rows[i].nf == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
      rows[i].sframe  = int'($urandom_range(0, 3));
      rows[i].bad_h   = int'($urandom_range(0, 4)) - 1;
      rows[i].bad_v   = int'($urandom_range(0, 4)) - 1;
      rows[i].coinc   = 1'($urandom_range(0, 1));
      rows[i].ss_idle = 1'b0;
      rows[i].restart = 1'($urandom_range(0, 1));
      rows[i]         = ref_model(rows[i]);
    end
    for (int i = 0; i < 16; i++) run_row(rows[i], i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
